pe_dot_sequencer: RTL and testbench
===================================

Name: pe_dot_sequencer

Overview:
Initiator and collector for a single procElem floating-point MAC. It accepts a valid/ready stream of IEEE-754 single operand pairs terminated by a last flag, and clears the PE before each vector. It drives A/B into the PE one pair per cycle, waits out the PE pipeline, then returns the accumulated dot product on a valid/ready result port. It sits between the CNN operand buffers and one PE.

Parameters:
PE_LAT, 1, cycles from a pair on pe_a/pe_b to its contribution visible on pe_c
MAX_LEN, 256, maximum pairs per vector before forced termination
CNT_W, 9, width of the pair counter (must hold MAX_LEN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts pair
in_a  in  32  operand A (fp32)
in_b  in  32  operand B (fp32)
in_last  in  1  final pair of the vector
pe_clr  out  1  synchronous accumulator clear to PE (drives PE rst)
pe_a  out  32  A to PE, registered
pe_b  out  32  B to PE, registered
pe_c  in  32  PE accumulator output
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  32  captured dot product (fp32)
res_count  out  CNT_W  pairs accumulated
res_ovf  out  1  vector truncated at MAX_LEN

Behaviour:
- Reset (async, rst=1): state=CLEAR, pe_a=pe_b=0, pe_clr=0, in_ready=0, res_valid=0, res_data=0, res_count=0, res_ovf=0, counters=0. Reset mid-vector discards all in-flight data; no partial result is ever emitted.
- States: CLEAR, FEED, DRAIN, OUT.
- CLEAR: exactly one cycle. pe_clr=1, pe_a=pe_b=0, in_ready=0, pair count cleared. Next state is FEED.
- FEED: in_ready=1. On handshake (in_valid&in_ready), pe_a<=in_a, pe_b<=in_b and count++. Otherwise pe_a<=0, pe_b<=0, which adds +0.0 and leaves the result bit-exact.
- FEED exits to DRAIN on a handshake with in_last=1, or on the handshake that makes count==MAX_LEN. In the MAX_LEN case res_ovf<=1 when in_last=0. When in_last=1 at exactly MAX_LEN, res_ovf=0.
- DRAIN: in_ready=0, pe_a/pe_b<=0. A drain counter is loaded with PE_LAT on entry and decremented each cycle. In the cycle the counter is 0: res_data<=pe_c, res_count<=count, next state is OUT.
- Latency: last handshake in cycle t, then pe_a/pe_b hold that pair in t+1, and res_valid rises in t+2+PE_LAT (t+3 at default).
- OUT: res_valid=1. res_data, res_count and res_ovf are held stable until res_ready. On res_valid&res_ready, go to CLEAR; res_valid drops the next cycle and res_ovf clears.
- Back-to-back throughput: (N pairs) + PE_LAT + 3 cycles per vector, with zero stall.
- in_ready is a registered decode of state and never depends combinationally on in_valid.
- in_valid low mid-vector inserts zero bubbles; pair order is preserved.
- All outputs are registered.

Test Plan:
- Reset then idle: rst pulse -> exactly one pe_clr cycle, then in_ready=1, res_valid=0, pe_a=pe_b=0.
- Two-pair vector: (0x40000000,0x40400000), then (0x3F800000,0x40A00000, last) on consecutive cycles -> res_data=0x41300000 (11.0), res_count=2, res_ovf=0, res_valid at last-handshake+3 cycles.
- Single pair with bubbles: (0xC2BDBD14,0xC308CFE6,last) with in_valid toggled and res_ready held low 5 cycles -> res_data=0x464ACD11 ±2 ULP, held stable all 5 cycles, res_count=1.
- Overflow: MAX_LEN=4, six pairs of (1.0,1.0) with no last -> result 0x40800000 (4.0), res_count=4, res_ovf=1; pairs 5 and 6 are accepted only after the next CLEAR, as a new vector.
- Async reset mid-FEED after 3 pairs -> outputs return to reset values immediately, no res_valid. A following 1-pair vector (2.0×2.0) -> 0x40800000.
- Back-to-back vectors with res_ready=1 -> second result is unaffected by the first (PE cleared), throughput matches N+PE_LAT+3.

Source files
------------

// File: rtl/pe_dot_sequencer_if.sv
// Operand stream, PE drive and result port bundle for pe_dot_sequencer.
// master is the sequencer side; slave is the buffer/PE/consumer side.
interface pe_dot_sequencer_if #(
  parameter int unsigned CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_last;
  logic             pe_clr;
  logic [31:0]      pe_a;
  logic [31:0]      pe_b;
  logic [31:0]      pe_c;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;

  modport master (
    input  in_valid, in_a, in_b, in_last, pe_c, res_ready,
    output in_ready, pe_clr, pe_a, pe_b, res_valid, res_data, res_count, res_ovf
  );

  modport slave (
    output in_valid, in_a, in_b, in_last, pe_c, res_ready,
    input  in_ready, pe_clr, pe_a, pe_b, res_valid, res_data, res_count, res_ovf
  );
endinterface

// File: rtl/pe_dot_sequencer.sv
// Feeds fp32 operand pairs into one MAC PE, waits out its pipeline and returns
// the accumulated dot product. All outputs are registered.
module pe_dot_sequencer #(
   parameter int unsigned PE_LAT  = 1,
   parameter int unsigned MAX_LEN = 256,
   parameter int unsigned CNT_W   = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   pe_dot_sequencer_if.master    bus
);

   localparam int unsigned DW = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_LEN);

   typedef enum logic [1:0] {StClear, StFeed, StDrain, StOut} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [DW-1:0]    drain_q, drain_d;
   logic [31:0]      pe_a_q, pe_a_d, pe_b_q, pe_b_d;
   logic             pe_clr_q, in_ready_q, res_valid_q;
   logic [31:0]      res_data_q, res_data_d;
   logic [CNT_W-1:0] res_count_q, res_count_d;
   logic             res_ovf_q, res_ovf_d;
   logic             hs;

   assign hs      = bus.in_valid & in_ready_q;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      pe_a_d      = '0;
      pe_b_d      = '0;
      res_data_d  = res_data_q;
      res_count_d = res_count_q;
      res_ovf_d   = res_ovf_q;
      case (state_q)
         StClear: begin
            cnt_d = '0;
            // Leave only once pe_clr has actually been driven (covers the cycle after reset)
            if (pe_clr_q) state_d = StFeed;
         end
         StFeed: begin
            if (hs) begin
               pe_a_d = bus.in_a;
               pe_b_d = bus.in_b;
               cnt_d  = cnt_inc;
               if (bus.in_last || (cnt_inc == MaxCnt)) begin
                  state_d   = StDrain;
                  drain_d   = DW'(PE_LAT);
                  res_ovf_d = ~bus.in_last;
               end
            end
         end
         StDrain: begin
            if (drain_q == '0) begin
               res_data_d  = bus.pe_c;
               res_count_d = cnt_q;
               state_d     = StOut;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         StOut: begin
            if (bus.res_ready) begin
               state_d   = StClear;
               res_ovf_d = 1'b0;
            end
         end
         default: state_d = StClear;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StClear;
         cnt_q       <= '0;
         drain_q     <= '0;
         pe_a_q      <= '0;
         pe_b_q      <= '0;
         pe_clr_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_count_q <= '0;
         res_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         pe_a_q      <= pe_a_d;
         pe_b_q      <= pe_b_d;
         pe_clr_q    <= (state_d == StClear);
         in_ready_q  <= (state_d == StFeed);
         res_valid_q <= (state_d == StOut);
         res_data_q  <= res_data_d;
         res_count_q <= res_count_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.pe_clr    = pe_clr_q;
   assign bus.pe_a      = pe_a_q;
   assign bus.pe_b      = pe_b_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_count = res_count_q;
   assign bus.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Directed bench for pe_dot_sequencer with a behavioural fp32 MAC standing in
// for the PE (one-cycle latency, cleared by pe_clr).
module tb_pe_dot_sequencer;

   localparam int unsigned PeLat  = 1;
   localparam int unsigned MaxLen = 4;
   localparam int unsigned CntW   = 3;

   localparam logic [31:0] F1  = 32'h3F800000;
   localparam logic [31:0] F2  = 32'h40000000;
   localparam logic [31:0] F3  = 32'h40400000;
   localparam logic [31:0] F4  = 32'h40800000;
   localparam logic [31:0] F5  = 32'h40A00000;
   localparam logic [31:0] F10 = 32'h41200000;
   localparam logic [31:0] F11 = 32'h41300000;
   localparam logic [31:0] BA  = 32'hC2BDBD14;
   localparam logic [31:0] BB  = 32'hC308CFE6;
   localparam logic [31:0] BP  = 32'h464ACD11;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [31:0] acc = 32'h0;

   always #5 clk = ~clk;

   pe_dot_sequencer_if #(.CNT_W(CntW)) bus ();

   pe_dot_sequencer #(
      .PE_LAT  (PeLat),
      .MAX_LEN (MaxLen),
      .CNT_W   (CntW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Normal numbers only; denormals flush to zero
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] b;
      if (f[30:23] == 8'd0) return 0.0;
      b = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      logic [10:0] e;
      logic [23:0] m;
      logic        rnd;
      b = $realtobits(r);
      if (b[62:52] == 11'd0) return 32'h0;
      e   = b[62:52] - 11'd896;
      m   = {1'b0, b[51:29]};
      rnd = b[28] & ((|b[27:0]) | b[29]);
      m   = m + {23'd0, rnd};
      if (m[23]) e = e + 11'd1;
      return {b[63], e[7:0], m[22:0]};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      acc <= bus.pe_clr ? 32'h0 : r2f(f2r(acc) + f2r(bus.pe_a) * f2r(bus.pe_b));
   end
   assign bus.pe_c = acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      logic [31:0] d;
      d = (obs > exp) ? obs - exp : exp - obs;
      checks++;
      assert (d <= 32'd2) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (+-2 ulp)", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns the cycle index of the handshake
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                       output int hs);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_timeout", 32'(n < 50), 32'd1);
      hs = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_res(output int rv);
      int n;
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("res_timeout", 32'(n < 50), 32'd1);
      rv = cyc;
   endtask

   task automatic accept();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   initial begin
      int h1, h2, r, r2, n, nclr, nrdy;
      logic [31:0] prod;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pe_clr",   32'(bus.pe_clr),    32'd0);
      chk("rst_in_ready", 32'(bus.in_ready),  32'd0);
      chk("rst_res_vld",  32'(bus.res_valid), 32'd0);
      chk("rst_pe_a",     bus.pe_a,           32'd0);
      chk("rst_pe_b",     bus.pe_b,           32'd0);
      chk("rst_res_data", bus.res_data,       32'd0);
      chk("rst_res_cnt",  32'(bus.res_count), 32'd0);
      chk("rst_res_ovf",  32'(bus.res_ovf),   32'd0);

      rst  = 1'b0;
      nclr = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.pe_clr === 1'b1) nclr++;
      end
      chk("idle_clr_cycles", 32'(nclr), 32'd1);
      chk("idle_in_ready",   32'(bus.in_ready),  32'd1);
      chk("idle_res_vld",    32'(bus.res_valid), 32'd0);
      chk("idle_pe_a",       bus.pe_a,           32'd0);

      // 2*3 + 1*5 = 11
      send(F2, F3, 1'b0, h1);
      send(F1, F5, 1'b1, h2);
      chk("two_consec", 32'(h2 - h1), 32'd1);
      wait_res(r);
      chk("two_latency", 32'(r - h2), 32'd3);
      chk("two_data",    bus.res_data,       F11);
      chk("two_count",   32'(bus.res_count), 32'd2);
      chk("two_ovf",     32'(bus.res_ovf),   32'd0);
      accept();
      chk("two_vld_drop", 32'(bus.res_valid), 32'd0);

      // single pair behind idle bubbles, result held under backpressure
      repeat (3) @(negedge clk);
      send(BA, BB, 1'b1, h1);
      wait_res(r);
      prod = r2f(f2r(BA) * f2r(BB));
      chk_ulp("bub_ulp", bus.res_data, BP);
      for (int i = 0; i < 5; i++) begin
         chk("bub_hold_vld",  32'(bus.res_valid), 32'd1);
         chk("bub_hold_data", bus.res_data,       prod);
         chk("bub_hold_cnt",  32'(bus.res_count), 32'd1);
         @(negedge clk);
      end
      accept();

      // overflow: four 1.0*1.0 pairs fill MAX_LEN, fifth must wait
      for (int i = 0; i < 4; i++) send(F1, F1, 1'b0, h1);
      bus.in_valid = 1'b1;
      bus.in_a     = F1;
      bus.in_b     = F1;
      n    = 0;
      nrdy = 0;
      while (bus.res_valid !== 1'b1 && n < 50) begin
         if (bus.in_ready === 1'b1) nrdy++;
         @(negedge clk);
         n++;
      end
      chk("ovf_timeout",  32'(n < 50),         32'd1);
      chk("ovf_no_accept", 32'(nrdy),          32'd0);
      chk("ovf_data",     bus.res_data,        F4);
      chk("ovf_count",    32'(bus.res_count),  32'd4);
      chk("ovf_flag",     32'(bus.res_ovf),    32'd1);
      r = cyc;
      accept();
      chk("ovf_flag_clr", 32'(bus.res_ovf),    32'd0);
      send(F1, F1, 1'b0, h1);
      chk("ovf_p5_after_clear", 32'(h1 - r), 32'd2);
      send(F1, F1, 1'b0, h1);
      send(F1, F1, 1'b0, h1);

      // async reset mid-vector after 3 pairs
      rst = 1'b1;
      #1;
      chk("arst_pe_a",     bus.pe_a,           32'd0);
      chk("arst_pe_b",     bus.pe_b,           32'd0);
      chk("arst_in_ready", 32'(bus.in_ready),  32'd0);
      chk("arst_res_vld",  32'(bus.res_valid), 32'd0);
      chk("arst_res_cnt",  32'(bus.res_count), 32'd0);
      chk("arst_res_data", bus.res_data,       32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(F2, F2, 1'b1, h1);
      wait_res(r);
      chk("arst_vec_lat",   32'(r - h1),        32'd3);
      chk("arst_vec_data",  bus.res_data,       F4);
      chk("arst_vec_count", 32'(bus.res_count), 32'd1);
      chk("arst_vec_ovf",   32'(bus.res_ovf),   32'd0);
      accept();

      // back-to-back with res_ready held high
      bus.res_ready = 1'b1;
      send(F3, F3, 1'b0, h1);
      send(F1, F1, 1'b1, h2);
      wait_res(r);
      chk("b2b_a_data",  bus.res_data,       F10);
      chk("b2b_a_count", 32'(bus.res_count), 32'd2);
      send(F2, F2, 1'b1, h2);
      chk("b2b_period", 32'(h2 - h1), 32'(2 + PeLat + 3));
      wait_res(r2);
      chk("b2b_b_lat",   32'(r2 - h2),       32'd3);
      chk("b2b_b_data",  bus.res_data,       F4);
      chk("b2b_b_count", 32'(bus.res_count), 32'd1);
      @(negedge clk);
      bus.res_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
